// File: rtl/peak_pkg.sv
// rtl/peak_pkg.sv - shared widths, table/result records and FSM encodings for the window scheduler
package peak_pkg;

  localparam int AW = 12;
  localparam int YW = 14;

  typedef struct packed {
    logic [AW-1:0] start;
    logic [AW-1:0] span;
    logic          en;
  } win_t;

  typedef struct packed {
    logic [AW-1:0] x;
    logic [YW-1:0] y;
    logic          valid;
  } res_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_STORE  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  // A window may end exactly at the top of the sample RAM, hence the extra sum bit.
  function automatic logic win_in_range(input logic [AW-1:0] start, input logic [AW-1:0] span);
    logic [AW:0] sum;
    sum = {1'b0, start} + {1'b0, span};
    return sum <= {1'b1, {AW{1'b0}}};
  endfunction

endpackage

// File: rtl/peak_win_table.sv
// rtl/peak_win_table.sv - host cfg table, per-frame shadow copy and issuability decode of one entry
module peak_win_table
  import peak_pkg::*;
#(
  parameter int NWIN = 4,
  localparam int IW = $clog2(NWIN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [AW-1:0] cfg_start,
  input  logic [AW-1:0] cfg_span,
  input  logic          cfg_en,
  input  logic          snap,
  input  logic [IW-1:0] idx,
  output logic [AW-1:0] win_start,
  output logic [AW-1:0] win_span,
  output logic          issuable,
  output logic          range_err
);

  win_t cfg_tab [NWIN];
  win_t shd_tab [NWIN];
  win_t cur;
  logic in_range;

  // The snapshot copies the pre-write contents, so a write in the snapshot cycle lands in the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWIN; i++) begin
        cfg_tab[i] <= '0;
        shd_tab[i] <= '0;
      end
    end else begin
      if (snap) begin
        for (int i = 0; i < NWIN; i++) begin
          shd_tab[i] <= cfg_tab[i];
        end
      end
      if (cfg_we) begin
        cfg_tab[cfg_idx] <= '{start: cfg_start, span: cfg_span, en: cfg_en};
      end
    end
  end

  always_comb begin
    cur       = shd_tab[idx];
    in_range  = win_in_range(cur.start, cur.span);
    win_start = cur.start;
    win_span  = cur.span;
    issuable  = cur.en && (cur.span != '0) && in_range;
    range_err = cur.en && !in_range;
  end

endmodule

// File: rtl/peak_win_sched.sv
// rtl/peak_win_sched.sv - issues enabled table windows to the peak engine per frame and banks the results
module peak_win_sched #(
  parameter int NWIN   = 4,
  parameter int AW     = 12,
  parameter int YW     = 14,
  parameter int TO_CYC = 4096,
  localparam int IW    = $clog2(NWIN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [AW-1:0] cfg_start,
  input  logic [AW-1:0] cfg_span,
  input  logic          cfg_en,
  input  logic          frame_rdy,
  input  logic          err_clr,
  output logic          eng_start,
  output logic [AW-1:0] eng_ctr,
  output logic [AW-1:0] eng_span,
  input  logic          eng_done,
  input  logic          eng_pk_valid,
  input  logic [AW-1:0] eng_peak_x,
  input  logic [YW-1:0] eng_peak_y,
  input  logic [IW-1:0] res_rd_idx,
  output logic [AW-1:0] res_x,
  output logic [YW-1:0] res_y,
  output logic          res_valid,
  output logic          busy,
  output logic          frame_done,
  output logic          err_timeout,
  output logic          err_range,
  output logic          err_ovr
);
  import peak_pkg::*;

  localparam int CW = ($clog2(TO_CYC) > AW + 1) ? $clog2(TO_CYC) : AW + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [CW-1:0] to_cnt;
  logic          lat_valid;
  logic [AW-1:0] lat_x;
  logic [YW-1:0] lat_y;
  res_t          bank [NWIN];

  logic          snap;
  logic          last;
  logic          timeout;
  logic          win_hold;
  logic          issuable;
  logic          range_err;
  logic [AW-1:0] win_start;
  logic [AW-1:0] win_span;

  assign snap     = (state == S_IDLE) && frame_rdy;
  assign last     = (idx == IW'(NWIN - 1));
  assign timeout  = (state == S_WAIT) && !eng_done && (to_cnt == TO_LAST);
  assign win_hold = (state == S_ISSUE) || (state == S_WAIT) || (state == S_STORE);

  assign eng_start  = (state == S_ISSUE);
  assign eng_ctr    = win_hold ? win_start : '0;
  assign eng_span   = win_hold ? win_span : '0;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_FINISH);

  peak_win_table #(.NWIN(NWIN)) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_start (cfg_start),
    .cfg_span  (cfg_span),
    .cfg_en    (cfg_en),
    .snap      (snap),
    .idx       (idx),
    .win_start (win_start),
    .win_span  (win_span),
    .issuable  (issuable),
    .range_err (range_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      to_cnt    <= '0;
      lat_valid <= 1'b0;
      lat_x     <= '0;
      lat_y     <= '0;
      for (int i = 0; i < NWIN; i++) begin
        bank[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_rdy) begin
            idx   <= '0;
            state <= S_SCAN;
            for (int i = 0; i < NWIN; i++) begin
              bank[i].valid <= 1'b0;
            end
          end
        end
        S_SCAN: begin
          if (issuable) begin
            state <= S_ISSUE;
          end else if (last) begin
            state <= S_FINISH;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_ISSUE: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        // A done arriving on the expiry cycle still counts as a real result.
        S_WAIT: begin
          if (eng_done) begin
            lat_valid <= eng_pk_valid;
            lat_x     <= eng_peak_x;
            lat_y     <= eng_peak_y;
            state     <= S_STORE;
          end else if (to_cnt == TO_LAST) begin
            lat_valid <= 1'b0;
            lat_x     <= '0;
            lat_y     <= '0;
            state     <= S_STORE;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        S_STORE: begin
          bank[idx] <= '{x: lat_x, y: lat_y, valid: lat_valid};
          if (last) begin
            state <= S_FINISH;
          end else begin
            idx   <= idx + IW'(1);
            state <= S_SCAN;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_x     <= '0;
      res_y     <= '0;
      res_valid <= 1'b0;
    end else begin
      res_x     <= bank[res_rd_idx].x;
      res_y     <= bank[res_rd_idx].y;
      res_valid <= bank[res_rd_idx].valid;
    end
  end

  // A new error in the clearing cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
      err_range   <= 1'b0;
      err_ovr     <= 1'b0;
    end else begin
      err_timeout <= timeout | (err_timeout & ~err_clr);
      err_range   <= ((state == S_SCAN) && range_err) | (err_range & ~err_clr);
      err_ovr     <= (frame_rdy && busy) | (err_ovr & ~err_clr);
    end
  end

endmodule

// File: tb/tb_peak_win_sched.sv
// tb/tb_peak_win_sched.sv - self-checking bench for peak_win_sched with an engine model and frame reference
module tb_peak_win_sched;
  localparam int NWIN = 4;
  localparam int IW   = 2;
  localparam int AW   = 12;
  localparam int YW   = 14;
  localparam int TO   = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we, cfg_en, frame_rdy, err_clr;
  logic [IW-1:0] cfg_idx, res_rd_idx;
  logic [AW-1:0] cfg_start, cfg_span;
  logic          eng_start, eng_done, eng_pk_valid;
  logic [AW-1:0] eng_ctr, eng_span, eng_peak_x, res_x;
  logic [YW-1:0] eng_peak_y, res_y;
  logic          res_valid, busy, frame_done, err_timeout, err_range, err_ovr;

  always #5 clk = ~clk;

  peak_win_sched #(.NWIN(NWIN), .AW(AW), .YW(YW), .TO_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_start(cfg_start),
    .cfg_span(cfg_span), .cfg_en(cfg_en), .frame_rdy(frame_rdy), .err_clr(err_clr),
    .eng_start(eng_start), .eng_ctr(eng_ctr), .eng_span(eng_span), .eng_done(eng_done),
    .eng_pk_valid(eng_pk_valid), .eng_peak_x(eng_peak_x), .eng_peak_y(eng_peak_y),
    .res_rd_idx(res_rd_idx), .res_x(res_x), .res_y(res_y), .res_valid(res_valid),
    .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout), .err_range(err_range),
    .err_ovr(err_ovr)
  );

  int checks = 0;
  int errors = 0;

  int tab_start [NWIN];
  int tab_span  [NWIN];
  bit tab_en    [NWIN];
  int rsp_lat [8];
  int rsp_x   [8];
  int rsp_y   [8];
  bit rsp_pkv [8];
  logic [2*AW-1:0] issues [$];
  int n_issue;
  int ovr_cyc = -1, clr_cyc = -1, wr_cyc = -1;
  int wr_start, wr_span;
  bit wr_en;

  typedef struct {
    int start;
    int span;
    bit en;
    int exp_issue;
    bit exp_rerr;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic program_entry(input int e, input int s, input int sp, input bit en);
    cfg_we = 1'b1; cfg_idx = IW'(e); cfg_start = AW'(s); cfg_span = AW'(sp); cfg_en = en;
    tick();
    cfg_we = 1'b0;
    tab_start[e] = s; tab_span[e] = sp; tab_en[e] = en;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr clears", {29'd0, err_timeout, err_range, err_ovr}, 0);
    tick();
  endtask

  // Engine: answers the k-th start of a frame after rsp_lat[k] cycles, or never when negative.
  initial begin
    eng_done = 1'b0; eng_pk_valid = 1'b0; eng_peak_x = '0; eng_peak_y = '0;
    n_issue = 0;
    forever begin
      @(negedge clk);
      if (rst_n && eng_start) begin
        int k;
        k = n_issue;
        issues.push_back({eng_ctr, eng_span});
        n_issue++;
        if (k < 8 && rsp_lat[k] >= 0) begin
          repeat (rsp_lat[k]) @(posedge clk);
          #1;
          eng_done = 1'b1; eng_pk_valid = rsp_pkv[k];
          eng_peak_x = AW'(rsp_x[k]); eng_peak_y = YW'(rsp_y[k]);
          @(posedge clk);
          #1;
          eng_done = 1'b0; eng_pk_valid = 1'b0;
        end
      end
    end
  end

  // Reference: each entry costs one scan cycle if skipped, else scan+issue+wait+store.
  task automatic run_frame(input string tag);
    int exp_cyc, k, w, sum, got;
    logic [2*AW-1:0] exp_q [$];
    bit exp_rv [NWIN];
    int exp_x [NWIN];
    int exp_y [NWIN];
    bit exp_to, exp_rg, exp_ovr;
    exp_cyc = 1; k = 0; exp_to = 0; exp_rg = 0;
    for (int e = 0; e < NWIN; e++) begin
      exp_rv[e] = 0; exp_x[e] = 0; exp_y[e] = 0;
      sum = tab_start[e] + tab_span[e];
      if (tab_en[e] && tab_span[e] != 0 && sum <= 4096) begin
        exp_q.push_back({AW'(tab_start[e]), AW'(tab_span[e])});
        if (rsp_lat[k] >= 1 && rsp_lat[k] <= TO) begin
          w = rsp_lat[k];
          exp_rv[e] = rsp_pkv[k]; exp_x[e] = rsp_x[k]; exp_y[e] = rsp_y[k];
        end else begin
          w = TO;
          exp_to = 1;
        end
        exp_cyc += 3 + w;
        k++;
      end else begin
        if (tab_en[e] && sum > 4096) exp_rg = 1;
        exp_cyc += 1;
      end
    end
    exp_ovr = (ovr_cyc >= 1 && ovr_cyc <= exp_cyc);

    issues.delete();
    n_issue = 0;
    frame_rdy = 1'b1;
    got = -1;
    for (int c = 0; c < exp_cyc + 50 && got < 0; c++) begin
      @(negedge clk);
      if (frame_done) got = c;
      tick();
      frame_rdy = (c + 1 == ovr_cyc);
      err_clr   = (c + 1 == clr_cyc);
      cfg_we    = (c + 1 == wr_cyc);
      if (c + 1 == wr_cyc) begin
        cfg_idx = '0; cfg_start = AW'(wr_start); cfg_span = AW'(wr_span); cfg_en = wr_en;
        tab_start[0] = wr_start; tab_span[0] = wr_span; tab_en[0] = wr_en;
      end
    end
    frame_rdy = 1'b0; err_clr = 1'b0; cfg_we = 1'b0;
    chk({tag, " frame_done cycle"}, got, exp_cyc);
    @(negedge clk);
    chk({tag, " busy after frame"}, busy, 0);
    chk({tag, " issue count"}, issues.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < issues.size(); i++) begin
      chk($sformatf("%s issue%0d ctr/span", tag, i), issues[i], exp_q[i]);
    end
    chk({tag, " err_timeout"}, err_timeout, exp_to);
    chk({tag, " err_range"}, err_range, exp_rg);
    chk({tag, " err_ovr"}, err_ovr, exp_ovr);
    for (int e = 0; e < NWIN; e++) begin
      tick();
      res_rd_idx = IW'(e);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s res_valid%0d", tag, e), res_valid, exp_rv[e]);
      if (exp_rv[e]) begin
        chk($sformatf("%s res_x%0d", tag, e), res_x, exp_x[e]);
        chk($sformatf("%s res_y%0d", tag, e), res_y, exp_y[e]);
      end
    end
    tick();
  endtask

  task automatic basic_table();
    program_entry(0, 50, 30, 1);
    program_entry(1, 100, 80, 1);
    program_entry(2, 180, 240, 1);
    program_entry(3, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      rsp_lat[k] = 40; rsp_pkv[k] = 1; rsp_x[k] = 0; rsp_y[k] = 1000 * (k + 1);
    end
    rsp_x[0] = 60; rsp_x[1] = 120; rsp_x[2] = 200;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_we = 0; cfg_idx = '0; cfg_start = '0; cfg_span = '0; cfg_en = 0;
    frame_rdy = 0; err_clr = 0; res_rd_idx = '0;
    for (int e = 0; e < NWIN; e++) begin
      tab_start[e] = 0; tab_span[e] = 0; tab_en[e] = 0;
    end
    for (int k = 0; k < 8; k++) begin
      rsp_lat[k] = 20; rsp_pkv[k] = 1; rsp_x[k] = k; rsp_y[k] = k;
    end
    vecs[0] = '{4000, 96, 1, 1, 0};
    vecs[1] = '{4000, 97, 1, 0, 1};
    vecs[2] = '{4095, 1, 1, 1, 0};
    vecs[3] = '{4095, 2, 1, 0, 1};
    vecs[4] = '{0, 0, 1, 0, 0};
    vecs[5] = '{0, 4095, 1, 1, 0};
    vecs[6] = '{4000, 200, 0, 0, 0};
    vecs[7] = '{4000, 200, 1, 0, 1};
    vecs[8] = '{1, 4095, 1, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset flags", {26'd0, busy, eng_start, frame_done, err_timeout, err_range, err_ovr}, 0);
    chk("reset eng_ctr/span", {eng_ctr, eng_span}, 0);
    chk("reset res", {res_valid, res_x, res_y}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    run_frame("all_off");

    for (int v = 0; v < 9; v++) begin
      program_entry(0, vecs[v].start, vecs[v].span, vecs[v].en);
      clear_errors();
      rsp_lat[0] = 5;
      run_frame($sformatf("vec%0d", v));
      chk($sformatf("vec%0d issued", v), n_issue, vecs[v].exp_issue);
      @(negedge clk);
      chk($sformatf("vec%0d err_range", v), err_range, vecs[v].exp_rerr);
      tick();
    end

    basic_table();
    clear_errors();
    run_frame("basic");
    chk("basic issue count", n_issue, 3);

    rsp_lat[1] = -1;
    clear_errors();
    run_frame("timeout");
    @(negedge clk);
    chk("timeout sticky", err_timeout, 1);
    tick();

    basic_table();
    program_entry(1, 4000, 200, 1);
    clear_errors();
    run_frame("range");
    @(negedge clk);
    chk("range sticky", err_range, 1);
    tick();

    basic_table();
    clear_errors();
    ovr_cyc = 10; clr_cyc = 10; wr_cyc = 10;
    wr_start = 500; wr_span = 60; wr_en = 1;
    run_frame("overrun");
    ovr_cyc = -1; clr_cyc = -1; wr_cyc = -1;
    @(negedge clk);
    chk("overrun survives clear", err_ovr, 1);
    chk("overrun old entry0", issues.size() > 0 ? issues[0] : '1, {12'd50, 12'd30});
    tick();
    clear_errors();
    run_frame("after_write");
    chk("next frame new entry0", issues.size() > 0 ? issues[0] : '1, {12'd500, 12'd60});

    basic_table();
    rsp_lat[0] = TO;
    clear_errors();
    run_frame("coincide");
    @(negedge clk);
    chk("coincide no timeout", err_timeout, 0);
    tick();

    for (int f = 0; f < 6; f++) begin
      for (int e = 0; e < NWIN; e++) begin
        int s, sp;
        s = $urandom_range(0, 4095);
        case ($urandom_range(0, 3))
          0:       sp = 0;
          1:       sp = (4096 - s) & 4095;
          2:       sp = (4097 - s) & 4095;
          default: sp = $urandom_range(1, 300);
        endcase
        program_entry(e, s, sp, $urandom_range(0, 3) != 0);
      end
      for (int k = 0; k < 8; k++) begin
        rsp_lat[k] = $urandom_range(1, 50); rsp_pkv[k] = $urandom_range(0, 1);
        rsp_x[k] = $urandom_range(0, 4095); rsp_y[k] = $urandom_range(0, 16383);
      end
      clear_errors();
      run_frame($sformatf("rand%0d", f));
    end

    basic_table();
    rsp_lat[0] = -1;
    clear_errors();
    issues.delete();
    n_issue = 0;
    frame_rdy = 1'b1;
    tick();
    frame_rdy = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("midframe busy", busy, 1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort flags", {26'd0, busy, eng_start, frame_done, err_timeout, err_range, err_ovr}, 0);
    chk("abort eng_ctr/span", {eng_ctr, eng_span}, 0);
    chk("abort res", {res_valid, res_x, res_y}, 0);
    repeat (5) tick();
    chk("abort no restart", n_issue, 1);
    rst_n = 1'b1;
    for (int e = 0; e < NWIN; e++) begin
      tab_start[e] = 0; tab_span[e] = 0; tab_en[e] = 0;
    end
    tick();
    run_frame("post_reset_off");
    basic_table();
    run_frame("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/peak_win_sched.md
# peak_win_sched

Window scheduler for the peak-detection engine. It holds a host-programmed table of analysis windows, each a start index plus a span. On each frame-ready event it issues every enabled window to the engine through a start/done handshake. It collects each window's PeakX/PeakY into a readable result bank, guards every window with a timeout, and reports frame completion and sticky errors to the host.

## Interface
- NWIN, 4: number of table entries (power of 2, IW = log2(NWIN))
- AW, 12: sample-address width
- YW, 14: peak-amplitude width
- TO_CYC, 4096: engine-timeout limit in cycles per window

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  table write strobe
- cfg_idx  in  IW  table entry to write
- cfg_start  in  AW  window start index
- cfg_span  in  AW  window length
- cfg_en  in  1  entry enable
- frame_rdy  in  1  one-cycle pulse: sample RAM holds a new frame
- err_clr  in  1  clears sticky errors
- eng_start  out  1  one-cycle pulse starting the engine
- eng_ctr  out  AW  window start to the engine
- eng_span  out  AW  window span to the engine
- eng_done  in  1  one-cycle pulse: engine finished the window
- eng_pk_valid  in  1  qualifies eng_peak_x/y on the eng_done cycle
- eng_peak_x  in  AW  peak position
- eng_peak_y  in  YW  peak amplitude
- res_rd_idx  in  IW  result readback index
- res_x  out  AW  result readback data
- res_y  out  YW  result readback data
- res_valid  out  1  result readback data qualifier
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when a frame completes
- err_timeout  out  1  sticky error
- err_range  out  1  sticky error
- err_ovr  out  1  sticky error

## Operation
- **Tables.** Two tables exist: a cfg table and an active shadow table.
  - cfg_we writes the cfg table at any time.
  - At frame start the cfg table is copied into the shadow table, so writes made while busy apply to the next frame.
- **Entry validity.** An entry is issued only if all of the following hold:
  - en=1
  - span≠0
  - start+span ≤ 2^AW, computed as an (AW+1)-bit sum
  - An entry with en=1 that fails the range check is skipped and sets err_range.
- **FSM states:** IDLE, SCAN, ISSUE, WAIT, STORE, FINISH.
  - IDLE: on frame_rdy, snapshot the table, clear all result valid bits, set idx=0 → SCAN.
  - SCAN: if entry idx is issuable → ISSUE. Otherwise, if idx==NWIN-1 → FINISH, else idx++ and stay in SCAN. Each cycle evaluates one entry.
  - ISSUE: eng_start=1 for one cycle; clear the timeout counter → WAIT.
  - WAIT: on eng_done, latch eng_pk_valid/x/y → STORE. On counter==TO_CYC-1 without done, record invalid, set err_timeout → STORE. If done and timeout occur in the same cycle, done wins.
  - STORE: write the result bank entry idx, with valid=latched pk_valid → next SCAN, or FINISH if idx==NWIN-1.
  - FINISH: frame_done=1 for one cycle → IDLE.
- **Engine outputs.** eng_ctr/eng_span hold the shadow values of entry idx from ISSUE through STORE.
- **Readback.** Results are registered: res_* reflect res_rd_idx one cycle after it is applied.
- **Overrun.** frame_rdy while busy is ignored and sets err_ovr.
- **Error clearing.** err_clr clears all sticky bits. If err_clr and a new error arrive in the same cycle, set wins.
- **eng_done outside WAIT** is ignored.
- **Timeout counter** is AW+1 bits minimum and saturates at TO_CYC-1.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; both tables and all result valid bits cleared.
- **Reset mid-frame** aborts immediately. Engine state is the engine's concern: it sees no further eng_start.
- **busy** =1 in every state except IDLE.
- **Latency to first issue:** frame_rdy in cycle 0 → SCAN in cycle 1 → eng_start in cycle 2 if entry 0 is issuable.
- **Skipped entries** cost 1 cycle each.
- **Inter-window gap:** eng_done at cycle t → STORE at t+1 → SCAN at t+2 → next eng_start at t+3 at the earliest.
- **Frame end:** last STORE (or last SCAN skip) at cycle t → frame_done at t+1 → busy=0 at t+2.
- **All entries disabled:** frame_done 1+NWIN cycles after frame_rdy (NWIN SCAN cycles, then FINISH).

## Structure
- **Package peak_pkg:** AW/YW defaults, typedef win_t {start, span, en}, typedef res_t {x, y, valid}, and the FSM state enum.
- **Sub-module peak_win_table:** cfg table plus shadow table, with snapshot strobe, write port and a combinational issuable/range-error decode for entry idx.
- **Main module:** the FSM, timeout counter, result bank and error logic.

## Test plan
- Entries 0..3 = (50,30), (100,80), (180,240), (0,0 en=0); frame_rdy; engine model responds 40 cycles after each start with x=60/120/200 → three eng_start pulses with the correct ctr/span, res_valid 1,1,1,0, one frame_done, busy drops.
- Engine never returns done on entry 1 → err_timeout set after TO_CYC cycles, entry 1 res_valid=0, entry 2 still issued, frame_done occurs.
- Entry with start=4000, span=200, en=1 → never issued, err_range set, other entries are unaffected.
- Second frame_rdy while busy, plus a cfg_we to entry 0 mid-frame → err_ovr set, the current frame uses the old entry 0, and the next frame issues the new value.
- eng_done in the same cycle as timeout expiry with pk_valid=1 → result valid, err_timeout stays 0. Also err_clr asserted in the same cycle as a new overrun → err_ovr remains 1.
- rst_n asserted during WAIT → all outputs 0 on the next edge, no eng_start afterward, and a clean frame completes after release.
